// File: rtl/aes_defs_pkg.sv
// rtl/aes_defs_pkg.sv - shared AES constants, FSM/update encodings and GF(2^8) helpers
package aes_defs_pkg;
    localparam logic       AES_128_BIT_KEY = 1'h0;
    localparam logic       AES_256_BIT_KEY = 1'h1;
    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;

    typedef enum logic [2:0] {
        CTRL_IDLE  = 3'd0,
        CTRL_INIT  = 3'd1,
        CTRL_SBOX  = 3'd2,
        CTRL_MAIN  = 3'd3,
        CTRL_FINAL = 3'd4
    } ctrl_state_t;

    typedef enum logic [2:0] {
        NO_UPDATE    = 3'd0,
        INIT_UPDATE  = 3'd1,
        SBOX_UPDATE  = 3'd2,
        MAIN_UPDATE  = 3'd3,
        FINAL_UPDATE = 3'd4
    } update_type_t;

    function automatic logic [3:0] num_rounds(input logic kl);
        logic [3:0] nr;
        nr = AES128_ROUNDS;
        case (kl)
            AES_128_BIT_KEY: nr = AES128_ROUNDS;
            AES_256_BIT_KEY: nr = AES256_ROUNDS;
            default:         nr = AES128_ROUNDS;
        endcase
        return nr;
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] op);
        return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] op);
        return gm2(op) ^ op;
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] op);
        return gm2(gm2(op));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] op);
        return gm2(gm4(op));
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] op);
        return gm8(op) ^ op;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] op);
        return gm8(op) ^ gm2(op) ^ op;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] op);
        return gm8(op) ^ gm4(op) ^ op;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] op);
        return gm8(op) ^ gm4(op) ^ gm2(op);
    endfunction

    function automatic logic [31:0] inv_mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3),
                gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
                gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3),
                gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3)};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] d);
        return {inv_mixw(d[127:96]), inv_mixw(d[95:64]), inv_mixw(d[63:32]), inv_mixw(d[31:0])};
    endfunction

    // Columns are 32-bit words; row r of the output takes column (c - r) mod 4.
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] d);
        return {d[127:120], d[23:16],   d[47:40],   d[71:64],
                d[95:88],   d[119:112], d[15:8],    d[39:32],
                d[63:56],   d[87:80],   d[111:104], d[7:0],
                d[31:24],   d[55:48],   d[79:72],   d[103:96]};
    endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - four parallel AES inverse S-box lookups on one 32-bit word
module aes_inv_sbox (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign o_word = {INV_SBOX[i_word[31:24]], INV_SBOX[i_word[23:16]],
                     INV_SBOX[i_word[15:8]],  INV_SBOX[i_word[7:0]]};
endmodule

// File: rtl/aes_decipher_block.sv
// rtl/aes_decipher_block.sv - iterative AES-128/256 inverse cipher, one S-box word per cycle
module aes_decipher_block
    import aes_defs_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);
    ctrl_state_t  r_state;
    logic [3:0]   r_round_ctr;
    logic [1:0]   r_sword_ctr;
    logic         r_ready;
    logic [31:0]  r_w0, r_w1, r_w2, r_w3;

    update_type_t w_update;
    logic [127:0] w_state;
    logic [127:0] w_init_block;
    logic [127:0] w_main_block;
    logic [127:0] w_final_block;
    logic [31:0]  w_sbox_in;
    logic [31:0]  w_sbox_out;
    logic [3:0]   w_round_dec;

    assign w_state       = {r_w0, r_w1, r_w2, r_w3};
    assign w_init_block  = inv_shiftrows(block ^ round_key);
    assign w_main_block  = inv_shiftrows(inv_mixcolumns(w_state ^ round_key));
    assign w_final_block = w_state ^ round_key;
    // Saturating so a keylen change mid-run can never wrap the counter.
    assign w_round_dec   = (r_round_ctr != 4'd0) ? r_round_ctr - 4'd1 : 4'd0;

    assign round     = r_round_ctr;
    assign ready     = r_ready;
    assign new_block = w_state;

    always_comb begin
        w_sbox_in = r_w0;
        case (r_sword_ctr)
            2'd0:    w_sbox_in = r_w0;
            2'd1:    w_sbox_in = r_w1;
            2'd2:    w_sbox_in = r_w2;
            default: w_sbox_in = r_w3;
        endcase
    end

    always_comb begin
        w_update = NO_UPDATE;
        case (r_state)
            CTRL_INIT:  w_update = INIT_UPDATE;
            CTRL_SBOX:  w_update = SBOX_UPDATE;
            CTRL_MAIN:  w_update = MAIN_UPDATE;
            CTRL_FINAL: w_update = FINAL_UPDATE;
            default:    w_update = NO_UPDATE;
        endcase
    end

    aes_inv_sbox u_inv_sbox (
        .i_word (w_sbox_in),
        .o_word (w_sbox_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= CTRL_IDLE;
            r_round_ctr <= 4'd0;
            r_sword_ctr <= 2'd0;
            r_ready     <= 1'b1;
            r_w0        <= 32'd0;
            r_w1        <= 32'd0;
            r_w2        <= 32'd0;
            r_w3        <= 32'd0;
        end else begin
            case (w_update)
                INIT_UPDATE:  {r_w0, r_w1, r_w2, r_w3} <= w_init_block;
                MAIN_UPDATE:  {r_w0, r_w1, r_w2, r_w3} <= w_main_block;
                FINAL_UPDATE: {r_w0, r_w1, r_w2, r_w3} <= w_final_block;
                SBOX_UPDATE: begin
                    case (r_sword_ctr)
                        2'd0:    r_w0 <= w_sbox_out;
                        2'd1:    r_w1 <= w_sbox_out;
                        2'd2:    r_w2 <= w_sbox_out;
                        default: r_w3 <= w_sbox_out;
                    endcase
                end
                default: ;
            endcase

            case (r_state)
                CTRL_IDLE: begin
                    if (next) begin
                        r_round_ctr <= num_rounds(keylen);
                        r_ready     <= 1'b0;
                        r_state     <= CTRL_INIT;
                    end
                end
                CTRL_INIT, CTRL_MAIN: begin
                    r_round_ctr <= w_round_dec;
                    r_sword_ctr <= 2'd0;
                    r_state     <= CTRL_SBOX;
                end
                CTRL_SBOX: begin
                    r_sword_ctr <= r_sword_ctr + 2'd1;
                    if (r_sword_ctr == 2'd3) begin
                        r_state <= (r_round_ctr == 4'd0) ? CTRL_FINAL : CTRL_MAIN;
                    end
                end
                CTRL_FINAL: begin
                    r_ready <= 1'b1;
                    r_state <= CTRL_IDLE;
                end
                default: r_state <= CTRL_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decipher_block.sv
// tb/tb_aes_decipher_block.sv - self-checking bench for aes_decipher_block against a byte-level AES model
module tb_aes_decipher_block;
    typedef logic [15:0][127:0] rk_t;

    logic         clk;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    rk_t          rk_drv;
    logic [7:0]   fwd_sb [256];
    logic [7:0]   inv_sb [256];
    int           n_checks;
    int           n_errors;
    bit           checking;

    bit           m_busy;
    logic         m_ready;
    logic [3:0]   m_round;
    logic [127:0] m_result;
    logic [127:0] m_pending;
    int           m_rq [$];

    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_decipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    assign round_key = rk_drv[round];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_tables();
        logic [7:0] binv;
        for (int x = 0; x < 256; x++) begin
            binv = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) binv = 8'(y);
            fwd_sb[x] = binv ^ {binv[6:0], binv[7]} ^ {binv[5:0], binv[7:6]}
                        ^ {binv[4:0], binv[7:5]} ^ {binv[3:0], binv[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_sb[fwd_sb[x]] = 8'(x);
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {fwd_sb[w[31:24]], fwd_sb[w[23:16]], fwd_sb[w[15:8]], fwd_sb[w[7:0]]};
    endfunction

    function automatic rk_t expand(input logic [255:0] key, input logic kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_t         rk;
        int          nk;
        int          nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * i -: 32];
            end else begin
                t = w[i - 1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gf_mul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i - nk] ^ t;
            end
        end
        rk = '0;
        for (int r = 0; r <= nr; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return rk;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127 - 8 * i -: 8] = inv ? inv_sb[v[127 - 8 * i -: 8]] : fwd_sb[v[127 - 8 * i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        int           src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127 - 8 * (4 * c + r) -: 8] = v[127 - 8 * (4 * src + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(coef[(k - r + 4) % 4], v[127 - 8 * (4 * c + k) -: 8]);
                o[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input rk_t rk, input int nr);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < nr; r++) s = mix_cols(shift_rows(sub_bytes(s, 0), 0), 0) ^ rk[r];
        return shift_rows(sub_bytes(s, 0), 0) ^ rk[nr];
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input rk_t rk, input int nr);
        logic [127:0] s;
        s = ct ^ rk[nr];
        for (int r = nr - 1; r >= 1; r--) s = mix_cols(sub_bytes(shift_rows(s, 1), 1) ^ rk[r], 1);
        return sub_bytes(shift_rows(s, 1), 1) ^ rk[0];
    endfunction

    // Expected schedule: INIT shows Nr, then each round r = Nr-1..0 shows r for five cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy   <= 1'b0;
            m_ready  <= 1'b1;
            m_round  <= 4'd0;
            m_result <= '0;
            m_rq.delete();
        end else if (m_busy) begin
            if (m_rq.size() > 0) begin
                m_round <= 4'(m_rq.pop_front());
            end else begin
                m_busy   <= 1'b0;
                m_ready  <= 1'b1;
                m_result <= m_pending;
            end
        end else if (next) begin
            for (int r = (keylen ? 13 : 9); r >= 0; r--) repeat (5) m_rq.push_back(r);
            m_round   <= keylen ? 4'he : 4'ha;
            m_ready   <= 1'b0;
            m_busy    <= 1'b1;
            m_pending <= aes_dec(block, rk_drv, keylen ? 14 : 10);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("cyc ready", 128'(ready), 128'(m_ready));
            chk("cyc round", 128'(round), 128'(m_round));
            if (m_ready) chk("cyc new_block", new_block, m_result);
        end
    end

    task automatic run_op(input logic [255:0] k, input logic kl, input logic [127:0] ct,
                          input bit pulse_busy, output int lat, output int max_round);
        @(negedge clk);
        rk_drv = expand(k, kl);
        keylen = kl;
        block  = ct;
        next   = 1'b1;
        @(negedge clk);
        next      = 1'b0;
        lat       = 0;
        max_round = 0;
        while (ready == 1'b0 && lat < 200) begin
            lat++;
            if (int'(round) > max_round) max_round = int'(round);
            next = pulse_busy && (lat == 10 || lat == 30);
            @(negedge clk);
        end
        next = 1'b0;
    endtask

    task automatic round_trip(input logic kl, input int n);
        logic [255:0] k;
        logic [127:0] pt;
        int           guard;
        for (int i = 0; i < n; i++) begin
            k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            rk_drv = expand(k, kl);
            keylen = kl;
            block  = aes_enc(pt, rk_drv, kl ? 14 : 10);
            next   = 1'b1;
            @(negedge clk);
            guard = 0;
            while (ready == 1'b0 && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            chk(kl ? "rt256 latency" : "rt128 latency", 128'(guard), kl ? 128'd71 : 128'd51);
            chk(kl ? "rt256 plaintext" : "rt128 plaintext", new_block, pt);
        end
        next = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int maxr;
        clk      = 1'b0;
        reset_n  = 1'b0;
        next     = 1'b0;
        keylen   = 1'b0;
        block    = '0;
        rk_drv   = '0;
        checking = 1'b0;
        n_checks = 0;
        n_errors = 0;

        build_tables();
        chk("model enc c1", aes_enc(PT_C, expand(KEY_C1, 1'b0), 10), CT_C1);
        chk("model dec c1", aes_dec(CT_C1, expand(KEY_C1, 1'b0), 10), PT_C);
        chk("model enc c3", aes_enc(PT_C, expand(KEY_C3, 1'b1), 14), CT_C3);
        chk("model dec c3", aes_dec(CT_C3, expand(KEY_C3, 1'b1), 14), PT_C);

        repeat (3) @(negedge clk);
        chk("reset ready", 128'(ready), 128'd1);
        chk("reset round", 128'(round), 128'd0);
        chk("reset new_block", new_block, 128'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checking = 1'b1;

        run_op(KEY_C1, 1'b0, CT_C1, 1'b0, lat, maxr);
        chk("c1 latency", 128'(lat), 128'd51);
        chk("c1 plaintext", new_block, PT_C);
        chk("c1 max round", 128'(maxr), 128'd10);

        run_op(KEY_C3, 1'b1, CT_C3, 1'b0, lat, maxr);
        chk("c3 latency", 128'(lat), 128'd71);
        chk("c3 plaintext", new_block, PT_C);
        chk("c3 max round", 128'(maxr), 128'd14);

        run_op(KEY_C1, 1'b0, CT_C1, 1'b1, lat, maxr);
        chk("busy next latency", 128'(lat), 128'd51);
        chk("busy next plaintext", new_block, PT_C);

        @(negedge clk);
        rk_drv = expand(KEY_C1, 1'b0);
        keylen = 1'b0;
        block  = CT_C1;
        next   = 1'b1;
        @(negedge clk);
        next = 1'b0;
        repeat (19) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset ready", 128'(ready), 128'd1);
        chk("midreset round", 128'(round), 128'd0);
        chk("midreset new_block", new_block, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(KEY_C1, 1'b0, CT_C1, 1'b0, lat, maxr);
        chk("post reset latency", 128'(lat), 128'd51);
        chk("post reset plaintext", new_block, PT_C);

        round_trip(1'b0, 600);
        round_trip(1'b1, 600);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/aes_decipher_block.md
Name: aes_decipher_block

Overview:
Iterative AES inverse-cipher datapath and control for AES-128 and AES-256. It is the decryption counterpart of the encipher round block. It takes a ciphertext block and round keys from the key memory, indexed by the `round` output counting down, and produces the plaintext. It sits beside the encipher block under the AES core and shares the key memory. Substitution is done one 32-bit word per cycle through an internal inverse S-box.

Parameters:
- AES_128_BIT_KEY, 1'h0, keylen encoding for 128-bit keys
- AES_256_BIT_KEY, 1'h1, keylen encoding for 256-bit keys
- AES128_ROUNDS, 4'ha, Nr for AES-128
- AES256_ROUNDS, 4'he, Nr for AES-256

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- next  in  1  start pulse; sampled only in IDLE
- keylen  in  1  0 = AES-128, 1 = AES-256; must be held stable while busy
- round  out  4  current round-key index requested from key memory
- round_key  in  128  round key for index `round`, combinational from key memory
- block  in  128  ciphertext; sampled only in INIT
- new_block  out  128  state register; holds plaintext when ready = 1
- ready  out  1  1 = idle with result valid

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset reset_n is asynchronous and active-low.
- Reset values:
  - state words w0..w3 = 0, so new_block = 0.
  - round_ctr = 0, sword_ctr = 0, ready = 1, FSM = IDLE.
- State is four 32-bit word registers with per-word write enables. w0 = bits [127:96].
- Combinational helpers:
  - inv_shiftrows: row r rotated right by r bytes.
  - inv_mixcolumns: per-column multiply by {0e,0b,0d,09} using gm2/gm4/gm8 xtime chains.
  - addroundkey: XOR.
- FSM states are IDLE, INIT, SBOX, MAIN, FINAL (3-bit encoding 0..4).
- IDLE:
  - If next: round_ctr <= Nr (from keylen), ready <= 0, go to INIT.
  - Otherwise hold all state.
- INIT (round = Nr):
  - state <= inv_shiftrows(block ^ round_key).
  - round_ctr decrements; sword_ctr <= 0; go to SBOX.
- SBOX:
  - Word w[sword_ctr] drives the inverse S-box input. Only that word is written with the result.
  - sword_ctr increments.
  - When sword_ctr == 3: go to FINAL if round_ctr == 0, else go to MAIN.
- MAIN (round = r, with Nr-1 ≥ r ≥ 1):
  - state <= inv_shiftrows(inv_mixcolumns(state ^ round_key)).
  - round_ctr decrements; sword_ctr <= 0; go to SBOX.
- FINAL (round = 0):
  - state <= state ^ round_key; ready <= 1; go to IDLE.
- Latency:
  - Busy time is 1 + 4·Nr + (Nr−1) + 1 = 5·Nr+1 cycles.
  - ready is low for 51 cycles (AES-128) or 71 cycles (AES-256) after the next-sampling edge.
  - ready is high again at edge 52 or 72.
- Boundary conditions:
  - next while not IDLE: ignored; no restart.
  - next held high in IDLE: a new operation starts each time IDLE is reached.
  - keylen changing while busy: undefined result, but the FSM must still terminate. The FINAL exit depends on round_ctr == 0, not on Nr.
  - round_ctr is never decremented below 0.
  - Unused FSM encodings (5..7): return to IDLE on the next edge.
  - Reset asserted mid-operation: immediate return to reset values; round_key is ignored.
  - new_block is visible mid-operation but is only valid when ready = 1.
  - new_block holds its value through IDLE until the next INIT.

Decomposition:
- Shared package/header aes_defs holds:
  - keylen encodings and round-count constants
  - FSM and update-type encodings, shared with the encipher block
  - gm2/gm3 helpers, plus new gm4/gm8/gm09/gm11/gm13/gm14 helpers
- One sub-module, aes_inv_sbox:
  - Purely combinational, 32-bit word in / out.
  - Four 256-entry inverse S-box lookups.
  - Instantiated once inside aes_decipher_block.

Test Plan:
- FIPS-197 C.1 AES-128:
  - Stimulus: key 000102…0f (bench key model drives round_key from `round`), block 69c4e0d86a7b0430d8cdb78070b4c55a, pulse next.
  - Required: new_block = 00112233445566778899aabbccddeeff when ready rises, exactly 52 cycles later.
- FIPS-197 C.3 AES-256:
  - Stimulus: key 00…1f, block 8ea2b7ca516745bfeafc49904b496089, keylen = 1.
  - Required: same plaintext; ready rises after 72 cycles.
- Round sequencing:
  - Monitor `round` during AES-128.
  - Required sequence: INIT shows a; MAIN shows 9,8,…,1; FINAL shows 0. Never any value outside 0..a.
- next during busy:
  - Stimulus: re-pulse next at cycles 10 and 30 of an AES-128 operation.
  - Required: result and latency unchanged; no restart.
- Reset mid-operation:
  - Stimulus: assert reset_n = 0 at cycle 20.
  - Required: new_block = 0, ready = 1, round = 0 immediately.
  - Then a fresh C.1 run must yield the correct plaintext.
- Back-to-back round trip:
  - Stimulus: encipher random blocks with the encipher block, then decipher the outputs with next tied high.
  - Required: over 1000 blocks for both key lengths, every decipher output equals its original block.
